// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err strobes.
// Define UART_RX_MAJORITY_EN to take a 3-sample majority vote at every sample point.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nx;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic [DATA_BITS-1:0] r_byte;
    logic [DATA_BITS-1:0] w_byte_nx;
    logic                 r_valid;
    logic                 w_valid_nx;
    logic                 r_ferr;
    logic                 w_ferr_nx;

    logic r_sync1;
    logic r_sync2;
    logic w_rx;
    logic w_samp;

    // Both flops reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bit_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx};
        end
    end

    assign w_samp = (w_rx & r_hist[0])
                  | (w_rx & r_hist[1])
                  | (r_hist[0] & r_hist[1]);
`else
    assign w_samp = w_rx;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_byte  <= w_byte_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_byte_nx  = r_byte;
        w_valid_nx = 1'b0;
        w_ferr_nx  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nx = S_START;
                    w_cnt_nx   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_nx = '0;
                    if (!w_samp) begin
                        w_state_nx = S_DATA;
                        w_idx_nx   = '0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    // LSB arrives first; shifting right lands it at bit 0.
                    w_shift_nx = (r_shift >> 1)
                               | (DATA_BITS'(w_samp) << (DATA_BITS - 1));
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = '0;
                    if (w_samp) begin
                        w_byte_nx  = r_shift;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign byte_out  = r_byte;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver (CLKS_PER_BIT=4, DATA_BITS=8).
// Frames are driven at negedge, one line value per clock cycle.
module tb_uart_receiver;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          bit_in  = 1'b1;
    logic [DB-1:0] byte_out;
    logic          valid;
    logic          frame_err;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    int cyc       = 0;
    int start_cyc = 0;
    int valid_n   = 0;
    int ferr_n    = 0;
    int both_n    = 0;
    int busy_n    = 0;
    int        vtime[$];
    logic [7:0] vbyte[$];

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bit_in   (bit_in),
        .byte_out (byte_out),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            valid_n = valid_n + 1;
            vtime.push_back(cyc);
            vbyte.push_back(byte_out);
        end
        if (frame_err) ferr_n = ferr_n + 1;
        if (valid && frame_err) both_n = both_n + 1;
        if (busy) busy_n = busy_n + 1;
    end

    task automatic clear_mon();
        valid_n = 0;
        ferr_n  = 0;
        busy_n  = 0;
        vtime.delete();
        vbyte.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_in = 1'b1;
        end
    endtask

    // Frame cycle map: start 0..3, data bit k 4+4k..7+4k, stop 36..39.
    task automatic drive_frame(input logic [7:0] d, input logic stop,
                               input int glitch, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            logic v;
            @(negedge clk);
            if (i < 4) v = 1'b0;
            else if (i < 36) v = d[(i - 4) / 4];
            else v = stop;
            if (i == glitch) v = ~v;
            if (i == 0) start_cyc = cyc + 1;
            bit_in = v;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (byte_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_byte: got %h want 00", byte_out);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ferr: got %b want 0", frame_err);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        reset_n = 1'b1;
        idle(5);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        int lat;
        clear_mon();
        drive_frame(8'hA5, 1'b1, -1, 40);
        idle(12);
        lat = (vtime.size() > 0) ? vtime[0] - start_cyc : -1;
        n_cmp++;
        if (valid_n !== 1) begin
            n_err++;
            $display("FAIL single_count: got %0d want 1", valid_n);
        end
        n_cmp++;
        if (byte_out !== 8'hA5) begin
            n_err++;
            $display("FAIL single_byte: got %h want a5", byte_out);
        end
        n_cmp++;
        if (lat < 40 || lat > 42) begin
            n_err++;
            $display("FAIL single_latency: got %0d want 40..42", lat);
        end
        n_cmp++;
        if (ferr_n !== 0) begin
            n_err++;
            $display("FAIL single_ferr: got %0d want 0", ferr_n);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h00;
        exp[1] = 8'hFF;
        exp[2] = 8'h3C;
        clear_mon();
        for (int f = 0; f < 3; f++) drive_frame(exp[f], 1'b1, -1, 40);
        idle(12);
        n_cmp++;
        if (valid_n !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 3", valid_n);
        end
        if (vbyte.size() >= 3) begin
            for (int f = 0; f < 3; f++) begin
                n_cmp++;
                if (vbyte[f] !== exp[f]) begin
                    n_err++;
                    $display("FAIL b2b_byte%0d: got %h want %h",
                             f, vbyte[f], exp[f]);
                end
            end
            for (int f = 1; f < 3; f++) begin
                n_cmp++;
                if (vtime[f] - vtime[f-1] !== 40) begin
                    n_err++;
                    $display("FAIL b2b_gap%0d: got %0d want 40",
                             f, vtime[f] - vtime[f-1]);
                end
            end
        end
        n_cmp++;
        if (ferr_n !== 0) begin
            n_err++;
            $display("FAIL b2b_ferr: got %0d want 0", ferr_n);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge clk);
        bit_in = 1'b0;
        @(negedge clk);
        bit_in = 1'b1;
        idle(12);
        n_cmp++;
        if (valid_n !== 0) begin
            n_err++;
            $display("FAIL glitch_valid: got %0d want 0", valid_n);
        end
        n_cmp++;
        if (ferr_n !== 0) begin
            n_err++;
            $display("FAIL glitch_ferr: got %0d want 0", ferr_n);
        end
        n_cmp++;
        if (busy_n < 1 || busy_n > CPB / 2 + 1) begin
            n_err++;
            $display("FAIL glitch_busy_len: got %0d want 1..%0d",
                     busy_n, CPB / 2 + 1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        drive_frame(8'h5A, 1'b0, -1, 40);
        repeat (20) begin
            @(negedge clk);
            bit_in = 1'b0;
        end
        idle(12);
        n_cmp++;
        if (ferr_n !== 1) begin
            n_err++;
            $display("FAIL ferr_count: got %0d want 1", ferr_n);
        end
        n_cmp++;
        if (valid_n !== 0) begin
            n_err++;
            $display("FAIL ferr_valid: got %0d want 0", valid_n);
        end
        n_cmp++;
        if (byte_out !== 8'h3C) begin
            n_err++;
            $display("FAIL ferr_byte_kept: got %h want 3c", byte_out);
        end
        clear_mon();
        drive_frame(8'h12, 1'b1, -1, 40);
        idle(12);
        n_cmp++;
        if (valid_n !== 1 || byte_out !== 8'h12) begin
            n_err++;
            $display("FAIL ferr_recover: got %0d/%h want 1/12",
                     valid_n, byte_out);
        end
        n_cmp++;
        if (ferr_n !== 0) begin
            n_err++;
            $display("FAIL ferr_recover_ferr: got %0d want 0", ferr_n);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive_frame(8'h0F, 1'b1, -1, 22);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (byte_out !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_byte: got %h want 00", byte_out);
        end
        n_cmp++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_strobes: got %b%b want 00",
                     valid, frame_err);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_busy: got %b want 0", busy);
        end
        bit_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(12);
        n_cmp++;
        if (valid_n !== 0 || ferr_n !== 0) begin
            n_err++;
            $display("FAIL rst_mid_events: got %0d/%0d want 0/0",
                     valid_n, ferr_n);
        end
        clear_mon();
        drive_frame(8'hC3, 1'b1, -1, 40);
        idle(12);
        n_cmp++;
        if (valid_n !== 1 || byte_out !== 8'hC3) begin
            n_err++;
            $display("FAIL rst_mid_next: got %0d/%h want 1/c3",
                     valid_n, byte_out);
        end
    endtask

    task automatic test_sample_glitch();
        logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
        exp = 8'h81;
`else
        exp = 8'h85;
`endif
        clear_mon();
        drive_frame(8'h81, 1'b1, 14, 40);
        idle(12);
        n_cmp++;
        if (valid_n !== 1 || byte_out !== exp) begin
            n_err++;
            $display("FAIL sample_glitch: got %0d/%h want 1/%h",
                     valid_n, byte_out, exp);
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (both_n !== 0) begin
            n_err++;
            $display("FAIL strobe_overlap: got %0d want 0", both_n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_sample_glitch();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
